// File: rtl/safety_island_pkg.sv
// Shared definitions for the safety island timer array: register offsets,
// channel stride, CTRL/STATUS/CMD bit positions and the CTRL register layout.
// Optional cascade support is compiled in with SAFETY_ISLAND_TIMER_CASCADE_EN.
package safety_island_pkg;

  // Register byte offsets inside one channel window
  localparam logic [4:0] TimerCtrlOffset    = 5'h00;
  localparam logic [4:0] TimerCountOffset   = 5'h04;
  localparam logic [4:0] TimerCompareOffset = 5'h08;
  localparam logic [4:0] TimerStatusOffset  = 5'h0C;
  localparam logic [4:0] TimerCmdOffset     = 5'h10;

  localparam int unsigned TimerChannelStride = 32'h20;

  // CTRL bit positions
  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlOneshotBit    = 1;
  localparam int unsigned CtrlAutoreloadBit = 2;
  localparam int unsigned CtrlCmpIeBit      = 3;
  localparam int unsigned CtrlOvfIeBit      = 4;
  localparam int unsigned CtrlCascadeBit    = 5;
  localparam int unsigned CtrlPrescLsb      = 8;
  localparam int unsigned PrescMaxWidth     = 8;

  // STATUS and CMD bit positions
  localparam int unsigned StatusCmpBit = 0;
  localparam int unsigned StatusOvfBit = 1;
  localparam int unsigned CmdStartBit  = 0;
  localparam int unsigned CmdStopBit   = 1;
  localparam int unsigned CmdClrBit    = 2;

  typedef struct packed {
    logic [PrescMaxWidth-1:0] presc;
    logic                     cascade;
    logic                     ovf_ie;
    logic                     cmp_ie;
    logic                     autoreload;
    logic                     oneshot;
    logic                     en;
  } timer_ctrl_t;

  // Pack CTRL into its bus word; bits 7:6 and 31:16 read as zero
  function automatic logic [31:0] ctrl_to_word(input timer_ctrl_t c);
    return {16'h0000, c.presc, 2'b00, c.cascade, c.ovf_ie, c.cmp_ie,
            c.autoreload, c.oneshot, c.en};
  endfunction

  // Unpack a bus write into CTRL, dropping prescaler bits above the
  // implemented width and the cascade bit where cascading is not possible
  function automatic timer_ctrl_t word_to_ctrl(input logic [31:0] w,
                                               input int unsigned presc_width,
                                               input logic cascade_ok);
    timer_ctrl_t c;
    logic [PrescMaxWidth-1:0] mask;
    logic unused_bits;
    unused_bits  = ^{w[31:16], w[7:6]};
    mask         = 8'hFF >> (PrescMaxWidth - presc_width);
    c.en         = w[CtrlEnBit];
    c.oneshot    = w[CtrlOneshotBit];
    c.autoreload = w[CtrlAutoreloadBit];
    c.cmp_ie     = w[CtrlCmpIeBit];
    c.ovf_ie     = w[CtrlOvfIeBit];
    c.cascade    = w[CtrlCascadeBit] & cascade_ok;
    c.presc      = w[CtrlPrescLsb +: PrescMaxWidth] & mask;
    return c;
  endfunction

endpackage

// File: rtl/safety_island_timer_channel.sv
// One timer channel: CTRL/COUNT/COMPARE/STATUS registers, prescaler, tick
// resolution and level interrupts. In cascade mode the tick comes from the
// lower neighbour's overflow instead of the local prescaler.
module safety_island_timer_channel
  import safety_island_pkg::*;
#(
  parameter int unsigned CntWidth       = 32,
  parameter int unsigned PrescWidth     = 8,
  parameter bit          CascadeCapable = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [4:0]  offset,
  input  logic [31:0] wdata,
  input  logic        cascade_mode,
  input  logic        cascade_tick_i,
  output logic [31:0] rdata,
  output logic        cascade_sel,
  output logic        ovf_event,
  output logic [1:0]  irq
);

  timer_ctrl_t           ctrl_reg, ctrl_next;
  logic [CntWidth-1:0]   count_reg, count_next;
  logic [CntWidth-1:0]   compare_reg, compare_next;
  logic [PrescWidth-1:0] presc_cnt_reg, presc_cnt_next;
  logic                  cmp_pend_reg, cmp_pend_next;
  logic                  ovf_pend_reg, ovf_pend_next;

  logic ctrl_we, count_we, compare_we, status_we, cmd_we;
  logic cmd_start, cmd_stop, cmd_clr;
  logic presc_hit, tick, cmp_hit, ovf_hit;

  // Write strobes, tick resolution and next-state for every register
  always_comb begin
    ctrl_we    = wr_en && (offset == TimerCtrlOffset);
    count_we   = wr_en && (offset == TimerCountOffset);
    compare_we = wr_en && (offset == TimerCompareOffset);
    status_we  = wr_en && (offset == TimerStatusOffset);
    cmd_we     = wr_en && (offset == TimerCmdOffset);
    cmd_start  = cmd_we && wdata[CmdStartBit];
    cmd_stop   = cmd_we && wdata[CmdStopBit];
    cmd_clr    = cmd_we && wdata[CmdClrBit];

    presc_hit = (presc_cnt_reg == ctrl_reg.presc[PrescWidth-1:0]);
    tick      = ctrl_reg.en && (cascade_mode ? cascade_tick_i : presc_hit);
    cmp_hit   = tick && (count_reg == compare_reg);
    // A compare match with autoreload restarts from zero without overflowing
    ovf_hit   = tick && (count_reg == '1) && !(cmp_hit && ctrl_reg.autoreload);

    // CTRL: bus write, then START/STOP (STOP last), then one-shot disable last
    ctrl_next = ctrl_reg;
    if (ctrl_we)  ctrl_next = word_to_ctrl(wdata, PrescWidth, CascadeCapable);
    if (cmd_start) ctrl_next.en = 1'b1;
    if (cmd_stop)  ctrl_next.en = 1'b0;
    if (cmp_hit && ctrl_reg.oneshot) ctrl_next.en = 1'b0;

    // Prescaler runs only while enabled and not slaved to a cascade source
    presc_cnt_next = presc_cnt_reg;
    if (ctrl_reg.en && !cascade_mode)
      presc_cnt_next = presc_hit ? '0 : presc_cnt_reg + 1'b1;
    if (ctrl_we || cmd_clr) presc_cnt_next = '0;

    // COUNT: tick update, overridden by CLR, overridden by a direct write
    count_next = count_reg;
    if (tick) count_next = (cmp_hit && ctrl_reg.autoreload) ? '0 : count_reg + 1'b1;
    if (cmd_clr)  count_next = '0;
    if (count_we) count_next = wdata[CntWidth-1:0];

    compare_next = compare_reg;
    if (compare_we) compare_next = wdata[CntWidth-1:0];

    // Pending bits: W1C first so a same-cycle hardware event wins
    cmp_pend_next = cmp_pend_reg;
    ovf_pend_next = ovf_pend_reg;
    if (status_we && wdata[StatusCmpBit]) cmp_pend_next = 1'b0;
    if (status_we && wdata[StatusOvfBit]) ovf_pend_next = 1'b0;
    if (cmp_hit) cmp_pend_next = 1'b1;
    if (ovf_hit) ovf_pend_next = 1'b1;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg      <= '0;
      count_reg     <= '0;
      compare_reg   <= '0;
      presc_cnt_reg <= '0;
      cmp_pend_reg  <= 1'b0;
      ovf_pend_reg  <= 1'b0;
    end else begin
      ctrl_reg      <= ctrl_next;
      count_reg     <= count_next;
      compare_reg   <= compare_next;
      presc_cnt_reg <= presc_cnt_next;
      cmp_pend_reg  <= cmp_pend_next;
      ovf_pend_reg  <= ovf_pend_next;
    end
  end

  // Read mux; zero unless this channel is being read
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        TimerCtrlOffset:    rdata = ctrl_to_word(ctrl_reg);
        TimerCountOffset:   rdata[CntWidth-1:0] = count_reg;
        TimerCompareOffset: rdata[CntWidth-1:0] = compare_reg;
        TimerStatusOffset:  rdata[1:0] = {ovf_pend_reg, cmp_pend_reg};
        default:            rdata = '0;
      endcase
    end
  end

  assign irq         = {ovf_pend_reg & ctrl_reg.ovf_ie, cmp_pend_reg & ctrl_reg.cmp_ie};
  assign ovf_event   = ovf_hit;
  assign cascade_sel = ctrl_reg.cascade;

endmodule

// File: rtl/safety_island_timer_array.sv
// Multi-channel safety island timer: regbus address decode, read mux and
// channel cascade wiring. Define SAFETY_ISLAND_TIMER_CASCADE_EN to let an
// even channel chain the next odd channel as its upper half.
module safety_island_timer_array
  import safety_island_pkg::*;
#(
  parameter int unsigned NumTimers  = 1,
  parameter int unsigned CntWidth   = 32,
  parameter int unsigned PrescWidth = 8,
  parameter int unsigned AddrWidth  = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   reg_valid_i,
  input  logic                   reg_write_i,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic [31:0]            reg_wdata_i,
  output logic                   reg_ready_o,
  output logic [31:0]            reg_rdata_o,
  output logic                   reg_error_o,
  output logic [2*NumTimers-1:0] irq_o
);

  localparam int unsigned ChIdxWidth = AddrWidth - 5;
  localparam logic [AddrWidth:0] WindowEnd = (AddrWidth+1)'(NumTimers * TimerChannelStride);

  logic                  in_range, offset_ok, access_ok;
  logic [4:0]            offset;
  logic [ChIdxWidth-1:0] ch_idx;
  logic [31:0]           ch_rdata [NumTimers];
  logic [NumTimers-1:0]  cascade_sel, ovf_event, cascade_mode, cascade_tick;
  logic                  unused_addr, unused_cascade;

  assign offset      = {reg_addr_i[4:2], 2'b00};
  assign ch_idx      = reg_addr_i[AddrWidth-1:5];
  assign in_range    = ({1'b0, reg_addr_i} < WindowEnd);
  assign offset_ok   = (reg_addr_i[4:2] <= 3'd4);
  assign access_ok   = reg_valid_i && in_range && offset_ok;
  assign reg_error_o = reg_valid_i && !(in_range && offset_ok);
  assign reg_ready_o = 1'b1;

  assign unused_addr    = ^reg_addr_i[1:0];
  assign unused_cascade = ^{cascade_sel, ovf_event};

  for (genvar gi = 0; gi < NumTimers; gi++) begin : g_ch
    logic ch_sel;
    assign ch_sel = access_ok && (ch_idx == ChIdxWidth'(gi));

`ifdef SAFETY_ISLAND_TIMER_CASCADE_EN
    localparam bit CascadeCapable = ((gi % 2) == 0) && ((gi + 1) < NumTimers);
    if ((gi % 2) == 1) begin : g_upper
      assign cascade_mode[gi] = cascade_sel[gi-1];
      assign cascade_tick[gi] = cascade_sel[gi-1] & ovf_event[gi-1];
    end else begin : g_lower
      assign cascade_mode[gi] = 1'b0;
      assign cascade_tick[gi] = 1'b0;
    end
`else
    localparam bit CascadeCapable = 1'b0;
    assign cascade_mode[gi] = 1'b0;
    assign cascade_tick[gi] = 1'b0;
`endif

    safety_island_timer_channel #(
      .CntWidth       (CntWidth),
      .PrescWidth     (PrescWidth),
      .CascadeCapable (CascadeCapable)
    ) u_channel (
      .clk            (clk_i),
      .rst            (rst_i),
      .wr_en          (ch_sel && reg_write_i),
      .rd_en          (ch_sel && !reg_write_i),
      .offset         (offset),
      .wdata          (reg_wdata_i),
      .cascade_mode   (cascade_mode[gi]),
      .cascade_tick_i (cascade_tick[gi]),
      .rdata          (ch_rdata[gi]),
      .cascade_sel    (cascade_sel[gi]),
      .ovf_event      (ovf_event[gi]),
      .irq            (irq_o[2*gi +: 2])
    );
  end

  // Unselected channels drive zero, so the read mux is a plain OR
  always_comb begin
    reg_rdata_o = '0;
    for (int i = 0; i < NumTimers; i++) reg_rdata_o = reg_rdata_o | ch_rdata[i];
  end

endmodule

// File: tb/tb_safety_island_timer_array.sv
// Scoreboard bench for safety_island_timer_array (2 channels). Each bus
// transaction pushes its expected response; a monitor compares on every
// valid cycle. Honours SAFETY_ISLAND_TIMER_CASCADE_EN like the design.
module tb_safety_island_timer_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_valid = 1'b0;
  logic        reg_write = 1'b0;
  logic [11:0] reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic [3:0]  irq;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        chk_irq;
    logic [3:0]  irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;

  safety_island_timer_array #(
    .NumTimers  (2),
    .CntWidth   (32),
    .PrescWidth (8),
    .AddrWidth  (12)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .reg_valid_i (reg_valid),
    .reg_write_i (reg_write),
    .reg_addr_i  (reg_addr),
    .reg_wdata_i (reg_wdata),
    .reg_ready_o (reg_ready),
    .reg_rdata_o (reg_rdata),
    .reg_error_o (reg_error),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic push(input string name, input logic [31:0] d, input logic err,
                      input logic chk, input logic [3:0] irq_exp);
    exp_t e;
    e.name = name; e.rdata = d; e.err = err; e.chk_irq = chk; e.irq = irq_exp;
    exp_q.push_back(e);
  endtask

  task automatic bus(input logic wr, input logic [11:0] a, input logic [31:0] d);
    reg_valid = 1'b1; reg_write = wr; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_write = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    push($sformatf("wr_%03h", a), 32'h0, 1'b0, 1'b0, 4'h0);
    bus(1'b1, a, d);
  endtask

  task automatic wr_err(input logic [11:0] a, input logic [31:0] d, input string name);
    push(name, 32'h0, 1'b1, 1'b0, 4'h0);
    bus(1'b1, a, d);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic [3:0] irq_exp,
                    input string name);
    push(name, d, 1'b0, 1'b1, irq_exp);
    bus(1'b0, a, 32'h0);
  endtask

  task automatic rd_err(input logic [11:0] a, input string name);
    push(name, 32'h0, 1'b1, 1'b0, 4'h0);
    bus(1'b0, a, 32'h0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every presented response with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reg_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_txn: addr=%03h with no expectation queued", reg_addr);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (reg_rdata !== e.rdata || reg_error !== e.err || reg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got rdata=%08h err=%b ready=%b, expected rdata=%08h err=%b ready=1",
                     e.name, reg_rdata, reg_error, reg_ready, e.rdata, e.err);
          end else
            $display("txn %s: rdata=%08h err=%b ok", e.name, reg_rdata, reg_error);
          if (e.chk_irq) begin
            n_cmp++;
            if (irq !== e.irq) begin
              n_fail++;
              $display("FAIL %s_irq: got irq=%b, expected irq=%b", e.name, irq, e.irq);
            end
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and decode errors
    wait_cycles(3);
    rst = 1'b0;
    rd(12'h000, 32'h0, 4'h0, "rst_ctrl");
    rd(12'h004, 32'h0, 4'h0, "rst_count");
    rd(12'h008, 32'h0, 4'h0, "rst_compare");
    rd(12'h00C, 32'h0, 4'h0, "rst_status");
    rd(12'h010, 32'h0, 4'h0, "rst_cmd");
    rd_err(12'h040, "err_past_window");
    rd_err(12'h014, "err_offset_14");
    wr_err(12'h044, 32'h1, "err_write");

    // Prescaled compare: PRESC=3, COMPARE=5 -> pend 24 cycles after START
    wr(12'h000, 32'h0000_0308);
    wr(12'h008, 32'd5);
    wr(12'h010, 32'h1);
    wait_cycles(23);
    rd(12'h00C, 32'h0, 4'h0, "presc_pend_early");
    rd(12'h00C, 32'h1, 4'h1, "presc_pend_rise");
    rd(12'h004, 32'd6, 4'h1, "presc_count_after");
    rd(12'h000, 32'h0000_0309, 4'h1, "presc_ctrl_en");
    wr(12'h010, 32'h2);
    wr(12'h00C, 32'h1);
    rd(12'h00C, 32'h0, 4'h0, "presc_w1c");
    rd(12'h004, 32'd7, 4'h0, "presc_count_stopped");
    wr(12'h010, 32'h4);

    // One-shot autoreload: COMPARE=2, PRESC=0
    wr(12'h008, 32'd2);
    wr(12'h000, 32'h0000_000F);
    wait_cycles(2);
    rd(12'h00C, 32'h0, 4'h0, "oneshot_before");
    rd(12'h00C, 32'h1, 4'h1, "oneshot_match");
    rd(12'h004, 32'h0, 4'h1, "oneshot_count0");
    rd(12'h000, 32'h0000_000E, 4'h1, "oneshot_en_off");
    wait_cycles(10);
    rd(12'h004, 32'h0, 4'h1, "oneshot_hold");
    wr(12'h00C, 32'h1);

    // Overflow from 0xFFFF_FFFE, then W1C colliding with an overflow
    wr(12'h000, 32'h0);
    wr(12'h004, 32'hFFFF_FFFE);
    wr(12'h008, 32'h10);
    wr(12'h000, 32'h0000_0011);
    wait_cycles(1);
    rd(12'h00C, 32'h0, 4'h0, "ovf_before");
    rd(12'h00C, 32'h2, 4'h2, "ovf_set");
    rd(12'h004, 32'h1, 4'h2, "ovf_count_wrapped");
    wr(12'h000, 32'h0000_0010);
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h00C, 32'h2);
    rd(12'h00C, 32'h0, 4'h0, "ovf_cleared");
    wr(12'h000, 32'h0000_0011);
    wr(12'h00C, 32'h2);
    rd(12'h00C, 32'h2, 4'h2, "ovf_set_beats_w1c");
    wr(12'h00C, 32'h2);
    rd(12'h00C, 32'h0, 4'h0, "ovf_w1c_later");
    wr(12'h000, 32'h0);

    // COUNT write racing a tick, then asynchronous reset mid-count
    wr(12'h008, 32'h100);
    wr(12'h000, 32'h0000_0009);
    wr(12'h004, 32'h100);
    rd(12'h004, 32'h100, 4'h0, "swwrite_beats_tick");
    rd(12'h00C, 32'h1, 4'h1, "cmp_after_write");
    rst = 1'b1;
    rd(12'h004, 32'h0, 4'h0, "async_rst_count");
    wait_cycles(2);
    rst = 1'b0;
    rd(12'h00C, 32'h0, 4'h0, "post_rst_status");
    rd(12'h000, 32'h0, 4'h0, "post_rst_ctrl");

    // Cascade (or independent counting when the feature is compiled out)
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h000, 32'h0000_0020);
    wr(12'h020, 32'h0000_0001);
    wr(12'h010, 32'h1);
    wr(12'h010, 32'h2);
    rd(12'h004, 32'h0, 4'h0, "casc_ch0_count");
`ifdef SAFETY_ISLAND_TIMER_CASCADE_EN
    rd(12'h024, 32'h1, 4'h0, "casc_ch1_count");
    rd(12'h000, 32'h0000_0020, 4'h0, "casc_ch0_ctrl");
`else
    rd(12'h024, 32'h3, 4'h0, "indep_ch1_count");
    rd(12'h000, 32'h0, 4'h0, "indep_ch0_ctrl");
`endif
    rd(12'h020, 32'h0000_0001, 4'h0, "ch1_ctrl");

    wait_cycles(2);
    done = 1'b1;
    wait_cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
